// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// The zero register is hardwired and is excluded from both writes and reservations.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = reg_addr_t'(1'b0);

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending flag per architectural register plus a registered population count.
// The next-state vector is exported so the read ports can forward post-edge busy state.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(NREGS)-1:0]   wr_addr,
  input  logic                       rsv_en,
  input  logic [$clog2(NREGS)-1:0]   rsv_addr,
  input  logic                       flush,
  output logic [NREGS-1:0]           busy,
  output logic [NREGS-1:0]           busy_next,
  output logic [$clog2(NREGS):0]     busy_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0]    ZERO_ADDR = AW'(ZERO_REG);
  localparam logic [NREGS-1:0] ONE_HOT0  = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] busy_r;
  logic [AW:0]      busy_cnt_r;
  logic [NREGS-1:0] wr_mask_s;
  logic [NREGS-1:0] rsv_mask_s;
  logic [NREGS-1:0] busy_next_s;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] cnt;
    cnt = {(AW+1){1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {{AW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // A reservation is applied after the write clear so a same-cycle reserve wins; flush drops it.
  assign wr_mask_s   = (wr_en && (wr_addr != ZERO_ADDR)) ? (ONE_HOT0 << wr_addr) : {NREGS{1'b0}};
  assign rsv_mask_s  = (rsv_en && !flush && (rsv_addr != ZERO_ADDR)) ? (ONE_HOT0 << rsv_addr)
                                                                      : {NREGS{1'b0}};
  assign busy_next_s = ((flush ? {NREGS{1'b0}} : busy_r) & ~wr_mask_s) | rsv_mask_s;

  // Busy bits and their count advance together so the count always matches the stored vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= {NREGS{1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      busy_r     <= busy_next_s;
      busy_cnt_r <= popcount(busy_next_s);
    end
  end

  assign busy      = busy_r;
  assign busy_next = busy_next_s;
  assign busy_cnt  = busy_cnt_r;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NRD registered read ports, optional write forwarding and a busy scoreboard.
// Forwarding covers both data and busy state, so a bypassing read sees the post-edge view.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0]          rd_data_o,
  output logic [NRD-1:0]               rd_busy_o,
  input  logic                         wr_en_i,
  input  logic [$clog2(NREGS)-1:0]     wr_addr_i,
  input  logic [XLEN-1:0]              wr_data_i,
  input  logic                         rsv_en_i,
  input  logic [$clog2(NREGS)-1:0]     rsv_addr_i,
  input  logic                         flush_i,
  output logic [$clog2(NREGS):0]       busy_cnt_o
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0]     regs_r [NREGS];
  logic [NRD*XLEN-1:0] rd_data_r;
  logic [NRD-1:0]      rd_busy_r;
  logic [NRD*XLEN-1:0] rd_data_s;
  logic [NRD-1:0]      rd_busy_s;
  logic [NREGS-1:0]    busy_s;
  logic [NREGS-1:0]    busy_next_s;
  logic                wr_ok_s;

  assign wr_ok_s = wr_en_i && (wr_addr_i != ZERO_ADDR);

  reg_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .wr_en     (wr_en_i),
    .wr_addr   (wr_addr_i),
    .rsv_en    (rsv_en_i),
    .rsv_addr  (rsv_addr_i),
    .flush     (flush_i),
    .busy      (busy_s),
    .busy_next (busy_next_s),
    .busy_cnt  (busy_cnt_o)
  );

  // Read-port muxing; x0 is never written, so its storage stays at zero.
  always_comb begin
    rd_data_s = {(NRD*XLEN){1'b0}};
    rd_busy_s = {NRD{1'b0}};
    for (int p = 0; p < NRD; p++) begin
      if ((BYPASS != 0) && wr_ok_s && (rd_addr_i[p*AW +: AW] == wr_addr_i)) begin
        rd_data_s[p*XLEN +: XLEN] = wr_data_i;
      end else begin
        rd_data_s[p*XLEN +: XLEN] = regs_r[rd_addr_i[p*AW +: AW]];
      end
      rd_busy_s[p] = (BYPASS != 0) ? busy_next_s[rd_addr_i[p*AW +: AW]]
                                   : busy_s[rd_addr_i[p*AW +: AW]];
    end
  end

  // Storage array update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_r <= {(NRD*XLEN){1'b0}};
      rd_busy_r <= {NRD{1'b0}};
    end else begin
      rd_data_r <= rd_data_s;
      rd_busy_r <= rd_busy_s;
    end
  end

  assign rd_data_o = rd_data_r;
  assign rd_busy_o = rd_busy_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (defaults: XLEN=32, NREGS=32, NRD=2, BYPASS=1).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_reg_file_sb;
  import regfile_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  reg_addr_t   wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  reg_addr_t   rsv_addr;
  logic        flush;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  reg_file_sb dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .flush_i    (flush),
    .busy_cnt_o (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic read2(input reg_addr_t a0, input reg_addr_t a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); wr_addr = 5'd0; wr_data = 32'd0; rsv_addr = 5'd0;
    read2(5'd5, 5'd5);
    #12;
    n_checks++;
    if ({rd_data, rd_busy, busy_cnt} !== 72'd0) $display("FAIL reset_in data=%h busy=%b cnt=%0d want 0", rd_data, rd_busy, busy_cnt);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    step();
    n_checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL reset_read_x5 data=%h busy=%b cnt=%0d want 0/00/0", rd_data, rd_busy, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd0; read2(5'd0, 5'd0);
    step();
    n_checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL x0_same data=%h busy=%b cnt=%0d want 0/00/0", rd_data, rd_busy, busy_cnt);
    else n_pass++;
    idle(); step();
    n_checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL x0_after data=%h busy=%b cnt=%0d want 0/00/0", rd_data, rd_busy, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_reserve_write();
    rsv_en = 1'b1; rsv_addr = 5'd3; read2(5'd0, 5'd0);
    step();
    idle(); read2(5'd3, 5'd0);
    step();
    n_checks++;
    if (rd_busy !== 2'b01 || busy_cnt !== 6'd1 || rd_data[31:0] !== 32'd0) $display("FAIL rsv_x3 busy=%b cnt=%0d data=%h want 01/1/0", rd_busy, busy_cnt, rd_data[31:0]);
    else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234;
    step();
    n_checks++;
    if (rd_data[31:0] !== 32'h1234 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL bypass_x3 data=%h busy=%b cnt=%0d want 1234/00/0", rd_data[31:0], rd_busy, busy_cnt);
    else n_pass++;
    idle(); read2(5'd0, 5'd3);
    step();
    n_checks++;
    if (rd_data !== {32'h1234, 32'd0} || rd_busy !== 2'b00) $display("FAIL stored_x3 data=%h busy=%b want 00001234_00000000/00", rd_data, rd_busy);
    else n_pass++;
  endtask

  task automatic test_rsv_write_same();
    rsv_en = 1'b1; rsv_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
    read2(5'd0, 5'd0);
    step();
    idle(); read2(5'd7, 5'd7);
    step();
    n_checks++;
    if (rd_data !== {32'hA5, 32'hA5} || rd_busy !== 2'b11 || busy_cnt !== 6'd1) $display("FAIL same_x7 data=%h busy=%b cnt=%0d want a5/a5/11/1", rd_data, rd_busy, busy_cnt);
    else n_pass++;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    n_checks++;
    if (busy_cnt !== 6'd1 || rd_busy !== 2'b11) $display("FAIL rerserve_x7 cnt=%0d busy=%b want 1/11", busy_cnt, rd_busy);
    else n_pass++;
    idle();
  endtask

  task automatic test_flush();
    read2(5'd9, 5'd1);
    rsv_en = 1'b1; rsv_addr = 5'd1; step();
    rsv_addr = 5'd2; step();
    rsv_addr = 5'd4; step();
    n_checks++;
    if (busy_cnt !== 6'd4 || rd_busy !== 2'b10) $display("FAIL pre_flush cnt=%0d busy=%b want 4/10", busy_cnt, rd_busy);
    else n_pass++;
    flush = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hBEEF;
    step();
    n_checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) $display("FAIL flush cnt=%0d busy=%b want 0/00", busy_cnt, rd_busy);
    else n_pass++;
    idle(); read2(5'd2, 5'd9);
    step();
    n_checks++;
    if (rd_data !== {32'd0, 32'hBEEF} || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL flush_wr data=%h busy=%b cnt=%0d want 0/beef/00/0", rd_data, rd_busy, busy_cnt);
    else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    step();
    idle(); step();
    n_checks++;
    if (rd_data[63:32] !== 32'h77 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL nonbusy_wr data=%h busy=%b cnt=%0d want 77/00/0", rd_data[63:32], rd_busy, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55; read2(5'd0, 5'd0);
    step();
    wr_addr = 5'd11; wr_data = 32'h66; rsv_en = 1'b1; rsv_addr = 5'd12; read2(5'd10, 5'd12);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL async_rst data=%h busy=%b cnt=%0d want 0", rd_data, rd_busy, busy_cnt);
    else n_pass++;
    step();
    idle(); rst_n = 1'b1; read2(5'd10, 5'd11);
    step();
    n_checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL post_rst data=%h busy=%b cnt=%0d want 0/00/0", rd_data, rd_busy, busy_cnt);
    else n_pass++;
    read2(5'd12, 5'd12);
    step();
    n_checks++;
    if (rd_busy !== 2'b00 || busy_cnt !== 6'd0) $display("FAIL post_rst_rsv busy=%b cnt=%0d want 00/0", rd_busy, busy_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_reserve_write();
    test_rsv_write_same();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count, power of two, >= 2.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (0/1).
REQ-005 clk_i  input  1  single clock, all logic rising-edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 rd_addr_i  input  NRD x log2(NREGS)  read address per port.
REQ-008 rd_data_o  output  NRD x XLEN  registered read data per port.
REQ-009 rd_busy_o  output  NRD  registered busy flag of addressed register per port.
REQ-010 wr_en_i  input  1  write strobe.
REQ-011 wr_addr_i  input  log2(NREGS)  write address.
REQ-012 wr_data_i  input  XLEN  write data.
REQ-013 rsv_en_i  input  1  reserve strobe (issue marks destination pending).
REQ-014 rsv_addr_i  input  log2(NREGS)  register to reserve.
REQ-015 flush_i  input  1  clear all busy bits (pipeline flush).
REQ-016 busy_cnt_o  output  log2(NREGS)+1  number of registers currently busy.

Function
REQ-017 Register 0 SHALL read as 0 and not busy; writes and reservations to address 0 SHALL be ignored.
REQ-018 Write SHALL update register wr_addr_i on the rising edge where wr_en_i=1.
REQ-019 Read latency SHALL be 1 cycle: rd_data_o/rd_busy_o at edge N+1 reflect rd_addr_i sampled at edge N.
REQ-020 With BYPASS=1, a read sampling the address being written in the same cycle SHALL return wr_data_i; with BYPASS=0 it SHALL return the old value.
REQ-021 Each register SHALL have one busy bit: set by rsv_en_i, cleared by wr_en_i to that address.
REQ-022 Simultaneous rsv and write to the same nonzero address: data SHALL be written and busy SHALL remain/become set (new reservation wins).
REQ-023 Reserving an already-busy register SHALL leave it busy (no counting of multiple reservations).
REQ-024 Writing a non-busy register SHALL update data and leave busy clear.
REQ-025 rd_busy_o SHALL reflect busy state after that edge's updates when BYPASS=1 (write in same cycle clears it, reservation sets it); with BYPASS=0 it SHALL reflect the pre-edge state.
REQ-026 flush_i SHALL clear all busy bits at the edge; a rsv_en_i in the same cycle SHALL be dropped; a write in the same cycle SHALL still update data.
REQ-027 busy_cnt_o SHALL be registered and equal the population count of busy bits after each edge; range 0..NREGS-1.
REQ-028 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-029 rst_ni low SHALL asynchronously clear all registers, all busy bits, rd_data_o, rd_busy_o and busy_cnt_o to 0.
REQ-030 Reset asserted mid-operation SHALL discard any write, reservation or flush in that cycle; first post-reset read SHALL return 0.

Structure
REQ-031 Package regfile_pkg SHALL hold XLEN/NREGS defaults, reg_addr_t typedef and the zero-register constant.
REQ-032 Busy-bit array and population counter SHALL be a sub-module reg_scoreboard; data array and read ports stay in reg_file_sb.

Verification
REQ-033 Reset, then read x5 on both ports -> rd_data_o=0, rd_busy_o=0, busy_cnt_o=0.
REQ-034 Write x0=0xDEADBEEF, reserve x0, read x0 -> data 0, busy 0, busy_cnt_o=0.
REQ-035 Reserve x3; next cycle read x3 -> busy 1, cnt 1; write x3=0x1234 while reading x3 (BYPASS=1) -> data 0x1234, busy 0, cnt 0.
REQ-036 Same-cycle rsv x7 and write x7=0xA5 -> next read x7: data 0xA5, busy 1, cnt 1.
REQ-037 Reserve x1,x2,x4 over three cycles, then flush with rsv x9 -> cnt 0, x9 not busy.
REQ-038 Drop rst_ni mid-stream after writing x10=0x55 -> outputs 0 immediately, x10 reads 0 after release.
